// File: rtl/mt_checkpoint_ctrl_if.sv
// mt_checkpoint_ctrl_if: dispatch, resolve, CDB and restore bundle for the map-table checkpoint controller
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 31
`endif
`ifndef N
`define N 2
`endif
interface mt_checkpoint_ctrl_if #(
  parameter int DEPTH = `ARCH_REG_SZ,
  parameter int N = `N,
  parameter int B = 4,
  parameter int TAG_W = $clog2(B),
  parameter int REG_W = $clog2(DEPTH + 1),
  parameter int PHYS_W = 6
);
  logic ckpt_req;
  logic [DEPTH:0][PHYS_W:0] ckpt_mt;
  logic ckpt_grant;
  logic [TAG_W-1:0] ckpt_tag;
  logic full;
  logic resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic resolve_mispredict;
  logic [N-1:0] cdb_valid;
  logic [N-1:0][REG_W-1:0] cdb_reg_idx;
  logic [N-1:0][PHYS_W-1:0] cdb_phys_idx;
  logic restore_en;
  logic [DEPTH:0][PHYS_W:0] restore_mt;
  logic [B-1:0] squash_mask;
  logic [B-1:0] active_mask;
  modport master (
    output ckpt_req, ckpt_mt, resolve_valid, resolve_tag, resolve_mispredict, cdb_valid, cdb_reg_idx, cdb_phys_idx,
    input ckpt_grant, ckpt_tag, full, restore_en, restore_mt, squash_mask, active_mask
  );
  modport slave (
    input ckpt_req, ckpt_mt, resolve_valid, resolve_tag, resolve_mispredict, cdb_valid, cdb_reg_idx, cdb_phys_idx,
    output ckpt_grant, ckpt_tag, full, restore_en, restore_mt, squash_mask, active_mask
  );
endinterface

// File: rtl/mt_checkpoint_ctrl.sv
// mt_checkpoint_ctrl: branch checkpoints of the rename map table with CDB patching and mispredict restore
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 31
`endif
`ifndef N
`define N 2
`endif
module mt_checkpoint_ctrl #(
  parameter int DEPTH = `ARCH_REG_SZ,
  parameter int N = `N,
  parameter int B = 4,
  parameter int TAG_W = $clog2(B),
  parameter int REG_W = $clog2(DEPTH + 1),
  parameter int PHYS_W = 6
) (
  input logic clock,
  input logic reset,
  mt_checkpoint_ctrl_if.slave io
);
  logic [B-1:0] valid, kill, done, alloc;
  logic [B-1:0][B-1:0] older;
  logic [B-1:0][DEPTH:0][PHYS_W:0] snap, snap_upd;
  logic [TAG_W-1:0] free_idx;
  logic res_ok, mis, grant;
  assign io.full = &valid;
  assign io.active_mask = valid;
  assign res_ok = io.resolve_valid & valid[io.resolve_tag];
  assign mis = res_ok & io.resolve_mispredict;
  assign grant = io.ckpt_req & !io.full & !(io.resolve_valid & io.resolve_mispredict) & !io.restore_en & !reset;
  assign io.ckpt_grant = grant;
  assign io.ckpt_tag = grant ? free_idx : '0;
  assign done = {B{res_ok & !io.resolve_mispredict}} & (B'(1) << io.resolve_tag);
  assign alloc = {B{grant}} & (B'(1) << free_idx);
  always_comb begin
    free_idx = '0;
    for (int s = B - 1; s >= 0; s--) free_idx = valid[s] ? free_idx : TAG_W'(s);
  end
  // older[s] holds the slots allocated before s, so a mispredict kills everything younger than the tag
  always_comb begin
    snap_upd = snap;
    kill = '0;
    for (int s = 0; s < B; s++) begin
      for (int i = 0; i < N; i++)
        if (io.cdb_valid[i] && snap[s][io.cdb_reg_idx[i]][PHYS_W:1] == io.cdb_phys_idx[i])
          snap_upd[s][io.cdb_reg_idx[i]][0] = 1'b1;
      kill[s] = mis & valid[s] & (older[s][io.resolve_tag] | (TAG_W'(s) == io.resolve_tag));
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      older <= '0;
      io.restore_en <= 1'b0;
      io.restore_mt <= '0;
      io.squash_mask <= '0;
    end else begin
      valid <= (valid & ~kill & ~done) | alloc;
      for (int s = 0; s < B; s++) older[s] <= alloc[s] ? (valid & ~done) : (older[s] & ~done);
      io.restore_en <= mis;
      io.restore_mt <= mis ? snap_upd[io.resolve_tag] : '0;
      io.squash_mask <= kill;
    end
  end
  always_ff @(posedge clock)
    for (int s = 0; s < B; s++) snap[s] <= alloc[s] ? io.ckpt_mt : snap_upd[s];
endmodule

// File: tb/tb_mt_checkpoint_ctrl.sv
// tb_mt_checkpoint_ctrl: vector table, directed corner sequences and random traffic against an age-ordered model
module tb_mt_checkpoint_ctrl;
  localparam int DEPTH = 31, N = 2, B = 4, TAG_W = 2, REG_W = 5, PW = 6;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  mt_checkpoint_ctrl_if #(.DEPTH(DEPTH), .N(N), .B(B), .TAG_W(TAG_W), .REG_W(REG_W), .PHYS_W(PW)) cif ();
  mt_checkpoint_ctrl #(.DEPTH(DEPTH), .N(N), .B(B), .TAG_W(TAG_W), .REG_W(REG_W), .PHYS_W(PW)) dut (
    .clock(clock), .reset(reset), .io(cif)
  );
  typedef struct {
    logic req, rv;
    logic [1:0] rtag;
    logic rmis, g;
    logic [1:0] tag;
    logic f;
    logic [3:0] act;
  } vec_t;
  vec_t tbl [12];
  logic m_valid [B];
  int m_seq [B];
  logic [PW:0] m_snap [B][DEPTH+1];
  logic m_ren;
  logic [B-1:0] m_sq;
  logic [DEPTH:0][PW:0] m_rmt;
  logic [DEPTH:0][PW:0] mt_at [B];
  logic [DEPTH:0][PW:0] exp_mt;
  int seq_cnt, n_chk, n_fail;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic idle();
    cif.ckpt_req = 1'b0;
    cif.resolve_valid = 1'b0;
    cif.resolve_tag = '0;
    cif.resolve_mispredict = 1'b0;
    cif.cdb_valid = '0;
    cif.cdb_reg_idx = '0;
    cif.cdb_phys_idx = '0;
  endtask
  task automatic rand_mt();
    for (int r = 0; r <= DEPTH; r++) cif.ckpt_mt[r] = {PW'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
  endtask
  // one clock: check combinational outputs mid-cycle, advance the model, check registered outputs after the edge
  task automatic cycle();
    logic eg, ef, ok, mis, rs;
    int free, t;
    logic [PW:0] p [B][DEPTH+1];
    logic [B-1:0] kill, am;
    #2;
    rs = reset;
    ef = 1'b1;
    free = -1;
    for (int s = 0; s < B; s++) if (!m_valid[s]) begin
      ef = 1'b0;
      if (free < 0) free = s;
    end
    eg = cif.ckpt_req && !ef && !(cif.resolve_valid && cif.resolve_mispredict) && !m_ren && !rs;
    chk("grant", cif.ckpt_grant, eg);
    chk("tag", cif.ckpt_tag, eg ? free : 0);
    chk("full", cif.full, ef);
    t = int'(cif.resolve_tag);
    ok = cif.resolve_valid && m_valid[t];
    mis = ok && cif.resolve_mispredict;
    for (int s = 0; s < B; s++) for (int r = 0; r <= DEPTH; r++) p[s][r] = m_snap[s][r];
    for (int s = 0; s < B; s++) if (m_valid[s])
      for (int i = 0; i < N; i++)
        if (cif.cdb_valid[i] && m_snap[s][cif.cdb_reg_idx[i]][PW:1] == cif.cdb_phys_idx[i]) p[s][cif.cdb_reg_idx[i]][0] = 1'b1;
    kill = '0;
    if (mis) for (int s = 0; s < B; s++) if (m_valid[s] && (s == t || m_seq[s] > m_seq[t])) kill[s] = 1'b1;
    @(posedge clock);
    #1;
    if (rs) begin
      for (int s = 0; s < B; s++) m_valid[s] = 1'b0;
      m_ren = 1'b0;
      m_sq = '0;
      m_rmt = '0;
    end else begin
      m_ren = mis;
      m_sq = kill;
      m_rmt = '0;
      if (mis) for (int r = 0; r <= DEPTH; r++) m_rmt[r] = p[t][r];
      for (int s = 0; s < B; s++) if (kill[s] || (ok && !mis && s == t)) m_valid[s] = 1'b0;
      for (int s = 0; s < B; s++) for (int r = 0; r <= DEPTH; r++) m_snap[s][r] = p[s][r];
      if (eg) begin
        m_valid[free] = 1'b1;
        m_seq[free] = seq_cnt++;
        for (int r = 0; r <= DEPTH; r++) m_snap[free][r] = cif.ckpt_mt[r];
      end
    end
    for (int s = 0; s < B; s++) am[s] = m_valid[s];
    chk("restore_en", cif.restore_en, m_ren);
    chk("squash_mask", cif.squash_mask, m_sq);
    chk("restore_mt", cif.restore_mt, m_rmt);
    chk("active_mask", cif.active_mask, am);
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask
  task automatic alloc(input int tag);
    idle();
    rand_mt();
    cif.ckpt_req = 1'b1;
    mt_at[tag] = cif.ckpt_mt;
    #2 chk("alloc_tag", cif.ckpt_tag, tag);
    cycle();
  endtask
  task automatic resolve(input int tag, input logic m);
    idle();
    cif.resolve_valid = 1'b1;
    cif.resolve_tag = TAG_W'(tag);
    cif.resolve_mispredict = m;
    cycle();
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 4'b0001};
    tbl[1]  = '{1, 0, 0, 0, 1, 1, 0, 4'b0011};
    tbl[2]  = '{1, 0, 0, 0, 1, 2, 0, 4'b0111};
    tbl[3]  = '{1, 0, 0, 0, 1, 3, 0, 4'b1111};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 4'b1111};
    tbl[5]  = '{1, 1, 1, 0, 0, 0, 1, 4'b1101};
    tbl[6]  = '{1, 0, 0, 0, 1, 1, 0, 4'b1111};
    tbl[7]  = '{1, 1, 3, 1, 0, 0, 1, 4'b0101};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 4'b0101};
    tbl[9]  = '{1, 0, 0, 0, 1, 1, 0, 4'b0111};
    tbl[10] = '{0, 1, 3, 0, 0, 0, 0, 4'b0111};
    tbl[11] = '{0, 1, 3, 1, 0, 0, 0, 4'b0111};
    n_chk = 0;
    n_fail = 0;
    seq_cnt = 0;
    idle();
    rand_mt();
    repeat (2) @(posedge clock);
    #1;
    for (int s = 0; s < B; s++) begin
      m_valid[s] = 1'b0;
      m_seq[s] = 0;
    end
    m_ren = 1'b0;
    m_sq = '0;
    m_rmt = '0;
    chk("rst_active", cif.active_mask, 0);
    chk("rst_restore_en", cif.restore_en, 0);
    chk("rst_squash", cif.squash_mask, 0);
    chk("rst_restore_mt", cif.restore_mt, 0);
    cif.ckpt_req = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      idle();
      rand_mt();
      cif.ckpt_req = tbl[k].req;
      cif.resolve_valid = tbl[k].rv;
      cif.resolve_tag = tbl[k].rtag;
      cif.resolve_mispredict = tbl[k].rmis;
      #2;
      chk($sformatf("tbl%0d_grant", k), cif.ckpt_grant, tbl[k].g);
      chk($sformatf("tbl%0d_tag", k), cif.ckpt_tag, tbl[k].tag);
      chk($sformatf("tbl%0d_full", k), cif.full, tbl[k].f);
      cycle();
      chk($sformatf("tbl%0d_active", k), cif.active_mask, tbl[k].act);
    end
    do_reset();
    alloc(0);
    alloc(1);
    alloc(2);
    resolve(1, 1'b1);
    chk("nest_restore_en", cif.restore_en, 1);
    chk("nest_squash", cif.squash_mask, 4'b0110);
    chk("nest_active", cif.active_mask, 4'b0001);
    chk("nest_restore_mt", cif.restore_mt, mt_at[1]);
    idle();
    cycle();
    chk("nest_restore_once", cif.restore_en, 0);
    chk("nest_restore_mt_zero", cif.restore_mt, 0);
    do_reset();
    alloc(0);
    alloc(1);
    resolve(0, 1'b0);
    chk("ooo_active", cif.active_mask, 4'b0010);
    resolve(1, 1'b1);
    chk("ooo_squash", cif.squash_mask, 4'b0010);
    chk("ooo_active_after", cif.active_mask, 4'b0000);
    do_reset();
    idle();
    rand_mt();
    cif.ckpt_mt[5] = {6'd40, 1'b0};
    mt_at[0] = cif.ckpt_mt;
    cif.ckpt_req = 1'b1;
    cycle();
    idle();
    cif.cdb_valid = 2'b01;
    cif.cdb_reg_idx[0] = 5'd5;
    cif.cdb_phys_idx[0] = 6'd40;
    cycle();
    cif.cdb_phys_idx[0] = 6'd33;
    cycle();
    resolve(0, 1'b1);
    exp_mt = mt_at[0];
    exp_mt[5][0] = 1'b1;
    chk("cdb_r5", cif.restore_mt[5], {6'd40, 1'b1});
    chk("cdb_restore_mt", cif.restore_mt, exp_mt);
    do_reset();
    alloc(0);
    alloc(1);
    idle();
    cif.ckpt_req = 1'b1;
    cif.resolve_valid = 1'b1;
    cif.resolve_tag = 2'd1;
    cif.resolve_mispredict = 1'b1;
    #2 chk("coll_mis_grant", cif.ckpt_grant, 0);
    cycle();
    idle();
    cif.ckpt_req = 1'b1;
    #2 chk("coll_restore_grant", cif.ckpt_grant, 0);
    cycle();
    resolve(3, 1'b1);
    chk("coll_inv_active", cif.active_mask, 4'b0001);
    chk("coll_inv_restore", cif.restore_en, 0);
    do_reset();
    alloc(0);
    alloc(1);
    resolve(0, 1'b1);
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rstmid_restore_en", cif.restore_en, 0);
    chk("rstmid_squash", cif.squash_mask, 0);
    chk("rstmid_active", cif.active_mask, 0);
    chk("rstmid_restore_mt", cif.restore_mt, 0);
    for (int k = 0; k < 3000; k++) begin
      idle();
      rand_mt();
      reset = ($urandom_range(0, 199) == 0);
      cif.ckpt_req = ($urandom_range(0, 2) != 0);
      cif.resolve_valid = ($urandom_range(0, 2) == 0);
      cif.resolve_tag = TAG_W'($urandom_range(0, B - 1));
      cif.resolve_mispredict = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        cif.cdb_valid[i] = 1'($urandom_range(0, 1));
        cif.cdb_reg_idx[i] = REG_W'($urandom_range(1, DEPTH));
        cif.cdb_phys_idx[i] = PW'($urandom_range(0, 7));
      end
      cycle();
    end
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
